// File: rtl/div_restoring_seq.sv
// div_restoring_seq: sequential restoring divider, one quotient bit per clock
module div_restoring_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_p;
  logic [CW-1:0]    r_cnt;
  logic             r_dz;
  logic             w_accept, w_last;
  logic [WIDTH:0]   w_sh, w_t;
  logic [WIDTH-1:0] w_p_nx, w_dvd_nx;
  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(1));
  // The restored remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted trial needs the extra bit to expose the borrow.
  assign w_sh     = {r_p, r_dvd[WIDTH-1]};
  assign w_t      = w_sh - {1'b0, r_dvs};
  assign w_p_nx   = w_t[WIDTH] ? w_sh[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign w_dvd_nx = {r_dvd[WIDTH-2:0], ~w_t[WIDTH]};
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end
  // next state: a start in IDLE or FIN always launches RUN; divide-by-zero runs a single pass
  always_comb begin
    w_state_nx = r_state;
    if (w_accept)              w_state_nx = RUN;
    else if (r_state == FIN)   w_state_nx = IDLE;
    else if (w_last)           w_state_nx = FIN;
  end
  // handshake outputs decoded from state
  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == FIN);
  end
  // iteration datapath: operand capture, shift/trial-subtract/restore, counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_p   <= '0;
      r_cnt <= '0;
      r_dz  <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= A;
      r_dvs <= B;
      r_p   <= '0;
      r_dz  <= (B == '0);
      r_cnt <= (B == '0) ? CW'(1) : CW'(WIDTH);
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt - CW'(1);
      if (!r_dz) begin
        r_p   <= w_p_nx;
        r_dvd <= w_dvd_nx;
      end
    end
  end
  // results load only on the final RUN edge so no partial value is ever visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
    end else if (w_last) begin
      Q        <= r_dz ? '1 : w_dvd_nx;
      R        <= r_dz ? r_dvd : w_p_nx;
      div_zero <= r_dz;
    end
  end
endmodule

// File: tb/tb_div_restoring_seq.sv
// tb_div_restoring_seq: directed self-checking bench for the restoring divider
module tb_div_restoring_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic [3:0] Q, R;
  logic       busy, done, div_zero;
  int         n_cmp = 0, n_err = 0;

  div_restoring_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // issue one operation from a post-edge point; returns cycles until done and the results
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat,
                        output logic [3:0] q, output logic [3:0] r, output logic dz);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    q = Q; r = R; dz = div_zero;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if ({Q, R, busy, done, div_zero} !== 11'b0) begin n_err++; $display("FAIL reset_state: got %b expected 0", {Q, R, busy, done, div_zero}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL basic_busy[%0d]: got %b expected 10", i, {busy, done}); end
      @(posedge clk); #1;
    end
    n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL basic_done: got %b expected 01", {busy, done}); end
    n_cmp++; if (Q !== 4'd4) begin n_err++; $display("FAIL basic_q: got %0d expected 4", Q); end
    n_cmp++; if (R !== 4'd1) begin n_err++; $display("FAIL basic_r: got %0d expected 1", R); end
    n_cmp++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL basic_dz: got %b expected 0", div_zero); end
    @(posedge clk); #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL basic_idle: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_values;
    logic [3:0] ta[4] = '{4'd15, 4'd0, 4'd2, 4'd15};
    logic [3:0] tb[4] = '{4'd1, 4'd5, 4'd7, 4'd15};
    logic [3:0] eq[4] = '{4'd15, 4'd0, 4'd0, 4'd1};
    logic [3:0] er[4] = '{4'd0, 4'd0, 4'd2, 4'd0};
    int lat; logic [3:0] q, r; logic dz;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], lat, q, r, dz);
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL values_lat[%0d]: got %0d expected 4", i, lat); end
      n_cmp++; if (q !== eq[i]) begin n_err++; $display("FAIL values_q[%0d]: got %0d expected %0d", i, q, eq[i]); end
      n_cmp++; if (r !== er[i]) begin n_err++; $display("FAIL values_r[%0d]: got %0d expected %0d", i, r, er[i]); end
      n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL values_dz[%0d]: got %b expected 0", i, dz); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int lat; logic [3:0] q, r; logic dz;
    run_op(4'd9, 4'd0, lat, q, r, dz);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dz_lat: got %0d expected 1", lat); end
    n_cmp++; if (q !== 4'd15) begin n_err++; $display("FAIL dz_q: got %0d expected 15", q); end
    n_cmp++; if (r !== 4'd9) begin n_err++; $display("FAIL dz_r: got %0d expected 9", r); end
    n_cmp++; if (dz !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b expected 1", dz); end
    A = 4'd8; B = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if ({Q, R, div_zero} !== {4'd15, 4'd9, 1'b1}) begin n_err++; $display("FAIL dz_hold: got %0d/%0d/%b expected 15/9/1", Q, R, div_zero); end
    lat = 0;
    while (!done && lat < 50) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL dz_next_lat: got %0d expected 4", lat); end
    n_cmp++; if ({Q, R, div_zero} !== {4'd4, 4'd0, 1'b0}) begin n_err++; $display("FAIL dz_next: got %0d/%0d/%b expected 4/0/0", Q, R, div_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_busy;
    int lat;
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    A = 4'd6; B = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (!done && lat < 50) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL ignore_lat: got %0d expected 4", lat); end
    n_cmp++; if ({Q, R} !== {4'd4, 4'd1}) begin n_err++; $display("FAIL ignore_qr: got %0d/%0d expected 4/1", Q, R); end
    @(posedge clk); #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL ignore_not_queued: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_back_to_back;
    int lat;
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    A = 4'd12; B = 4'd5;
    lat = 0;
    while (!done && lat < 50) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL b2b_first_lat: got %0d expected 4", lat); end
    n_cmp++; if ({Q, R} !== {4'd4, 4'd1}) begin n_err++; $display("FAIL b2b_first_qr: got %0d/%0d expected 4/1", Q, R); end
    lat = 0;
    do begin @(posedge clk); #1; lat++; start = 1'b0; end while (!done && lat < 50);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL b2b_gap: got %0d expected 5", lat); end
    n_cmp++; if ({Q, R} !== {4'd2, 4'd2}) begin n_err++; $display("FAIL b2b_second_qr: got %0d/%0d expected 2/2", Q, R); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int lat; logic [3:0] q, r; logic dz;
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({Q, R, busy, done, div_zero} !== 11'b0) begin n_err++; $display("FAIL async_reset: got %b expected 0", {Q, R, busy, done, div_zero}); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL async_idle: got %b expected 00", {busy, done}); end
    run_op(4'd12, 4'd5, lat, q, r, dz);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL async_fresh_lat: got %0d expected 4", lat); end
    n_cmp++; if ({q, r, dz} !== {4'd2, 4'd2, 1'b0}) begin n_err++; $display("FAIL async_fresh: got %0d/%0d/%b expected 2/2/0", q, r, dz); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_values;
    test_div_zero;
    test_ignore_busy;
    test_back_to_back;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
